// File: rtl/tow_cyber_press.sv
// Synthetic tug-of-war opponent: an LFSR-gated press sequencer that emits an
// active-low KEY-style waveform plus a one-cycle fire pulse per press.
module tow_cyber_press #(
    parameter int HOLD = 2,
    parameter int GAP  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] difficulty,
    output logic       key_n,
    output logic       fire,
    output logic       busy,
    output logic [7:0] press_count,
    output logic [9:0] lfsr_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
    localparam logic [3:0] GAP_LD  = 4'(GAP - 1);

    // XNOR feedback keeps all-zeros legal; all-ones is the unreachable lockup.
    function automatic logic [9:0] lfsr_next(input logic [9:0] q);
        return {q[8:0], ~(q[9] ^ q[6])};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state, state_d;
    logic [3:0] timer, timer_d;
    logic       key_n_d;
    logic       fire_d;
    logic       trig;

    assign trig = enable && (lfsr_q[8:0] < difficulty);

    always_comb begin
        state_d = state;
        timer_d = timer;
        key_n_d = 1'b1;
        fire_d  = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_d = PRESS;
                    timer_d = HOLD_LD;
                    key_n_d = 1'b0;
                    fire_d  = 1'b1;
                end
            end
            PRESS: begin
                if (timer == 4'd0) begin
                    state_d = RELEASE;
                    timer_d = GAP_LD;
                end else begin
                    timer_d = timer - 4'd1;
                    key_n_d = 1'b0;
                end
            end
            RELEASE: begin
                if (timer == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q      <= 10'd0;
            state       <= IDLE;
            timer       <= 4'd0;
            key_n       <= 1'b1;
            fire        <= 1'b0;
            busy        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            state  <= state_d;
            timer  <= timer_d;
            key_n  <= key_n_d;
            fire   <= fire_d;
            busy   <= (state_d != IDLE);
            if (fire_d) begin
                press_count <= sat_inc(press_count);
            end
        end
    end

endmodule

// File: tb/tb_tow_cyber_press.sv
// Directed bench for tow_cyber_press: vector tables for the LFSR and
// always-fire sequences, plus hand-written enable-drop, reset and saturation runs.
module tb_tow_cyber_press;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [8:0] difficulty;
    logic       key_n;
    logic       fire;
    logic       busy;
    logic [7:0] press_count;
    logic [9:0] lfsr_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [8:0] diff;
        logic       key_n;
        logic       fire;
        logic       busy;
        logic [7:0] cnt;
        logic [9:0] lfsr;
    } vec_t;

    vec_t lfsr_tab[12];
    vec_t fire_tab[16];
    int   lf[16] = '{0, 1, 3, 7, 15, 31, 63, 127, 254, 508, 1016, 1009, 995, 967, 911, 798};

    tow_cyber_press #(.HOLD(2), .GAP(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .difficulty (difficulty),
        .key_n      (key_n),
        .fire       (fire),
        .busy       (busy),
        .press_count(press_count),
        .lfsr_q     (lfsr_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input string tag, input int c);
        chk($sformatf("%s[%0d].key_n", tag, c), int'(key_n), int'(v.key_n));
        chk($sformatf("%s[%0d].fire", tag, c), int'(fire), int'(v.fire));
        chk($sformatf("%s[%0d].busy", tag, c), int'(busy), int'(v.busy));
        chk($sformatf("%s[%0d].count", tag, c), int'(press_count), int'(v.cnt));
        chk($sformatf("%s[%0d].lfsr", tag, c), int'(lfsr_q), int'(v.lfsr));
    endtask

    initial begin
        int last_fire;
        int model_cnt;
        int low_run;
        int fires_after_sat;
        bit reached;

        // LFSR table: enable low, nothing fires
        for (int c = 0; c < 12; c++) begin
            lfsr_tab[c] = '{en: 1'b0, diff: 9'd511, key_n: 1'b1, fire: 1'b0,
                            busy: 1'b0, cnt: 8'd0, lfsr: 10'(lf[c])};
        end
        // Always-fire table: presses start at IDLE cycles 0, 6, 12
        for (int c = 0; c < 16; c++) begin
            fire_tab[c].en    = 1'b1;
            fire_tab[c].diff  = 9'd511;
            fire_tab[c].key_n = !(c == 1 || c == 2 || c == 7 || c == 8 || c == 13 || c == 14);
            fire_tab[c].fire  = (c == 1 || c == 7 || c == 13);
            fire_tab[c].busy  = (c >= 1 && c <= 5) || (c >= 7 && c <= 11) || c >= 13;
            fire_tab[c].cnt   = (c == 0) ? 8'd0 : (c <= 6) ? 8'd1 : (c <= 12) ? 8'd2 : 8'd3;
            fire_tab[c].lfsr  = 10'(lf[c]);
        end

        enable     = 1'b0;
        difficulty = 9'd0;

        // Reset state and LFSR sequence
        reset = 1'b1;
        step();
        chk("reset.key_n", int'(key_n), 1);
        chk("reset.fire", int'(fire), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.count", int'(press_count), 0);
        chk("reset.lfsr", int'(lfsr_q), 0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check_vec(lfsr_tab[c], "lfsr", c);
            enable     = lfsr_tab[c].en;
            difficulty = lfsr_tab[c].diff;
            step();
        end

        // Always fires from reset release
        do_reset();
        for (int c = 0; c < 16; c++) begin
            check_vec(fire_tab[c], "fire", c);
            enable     = fire_tab[c].en;
            difficulty = fire_tab[c].diff;
            step();
        end

        // Never fires with difficulty 0
        enable     = 1'b0;
        difficulty = 9'd0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (key_n !== 1'b1 || fire !== 1'b0) begin
                chk($sformatf("never.key_n_fire@%0d", c), int'({key_n, fire}), 2);
            end
            step();
        end
        chk("never.key_n", int'(key_n), 1);
        chk("never.count", int'(press_count), 0);

        // Enable drop on the first low cycle does not truncate the press
        enable     = 1'b0;
        difficulty = 9'd511;
        do_reset();
        enable = 1'b1;
        step();
        chk("drop.key_n_c1", int'(key_n), 0);
        chk("drop.fire_c1", int'(fire), 1);
        enable = 1'b0;
        step();
        chk("drop.key_n_c2", int'(key_n), 0);
        chk("drop.fire_c2", int'(fire), 0);
        for (int c = 3; c <= 5; c++) begin
            step();
            chk($sformatf("drop.key_n_c%0d", c), int'(key_n), 1);
            chk($sformatf("drop.busy_c%0d", c), int'(busy), 1);
        end
        for (int c = 6; c <= 15; c++) begin
            step();
            chk($sformatf("drop.idle_c%0d", c), int'({key_n, fire, busy}), 3'b100);
        end
        chk("drop.count", int'(press_count), 1);

        // Reset asserted mid-press
        enable = 1'b1;
        do_reset();
        step();
        chk("rstmid.key_n_before", int'(key_n), 0);
        reset = 1'b1;
        step();
        chk("rstmid.key_n", int'(key_n), 1);
        chk("rstmid.busy", int'(busy), 0);
        chk("rstmid.count", int'(press_count), 0);
        chk("rstmid.lfsr", int'(lfsr_q), 0);
        chk("rstmid.fire", int'(fire), 0);
        reset = 1'b0;

        // Saturation and spacing over a long run
        enable     = 1'b1;
        difficulty = 9'd511;
        do_reset();
        last_fire       = -100;
        model_cnt       = 0;
        low_run         = 0;
        fires_after_sat = 0;
        reached         = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (fire) begin
                if (c - last_fire < 6) begin
                    chk($sformatf("sat.spacing@%0d", c), c - last_fire, 6);
                end
                last_fire = c;
                if (model_cnt == 255) fires_after_sat++;
                if (model_cnt < 255) model_cnt++;
            end
            if (int'(press_count) != model_cnt) begin
                chk($sformatf("sat.count@%0d", c), int'(press_count), model_cnt);
            end
            if (!key_n) begin
                low_run++;
            end else begin
                if (low_run != 0 && low_run != 2) begin
                    chk($sformatf("sat.hold@%0d", c), low_run, 2);
                end
                low_run = 0;
            end
            if (press_count == 8'd255) reached = 1'b1;
            step();
        end
        chk("sat.reached", int'(reached), 1);
        chk("sat.final_count", int'(press_count), 255);
        chk("sat.model_count", int'(press_count), model_cnt);
        chk("sat.fires_continue", int'(fires_after_sat > 10), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
